// File: rtl/nv_nvdla_sdp_cvt_pkg.sv
// Shared constants and helpers for the SDP Y cvt output-channel wait datapath.
// Imported by the per-channel slot and by the multi-channel top.
package nv_nvdla_sdp_cvt_pkg;

  localparam int MODE_INDEP    = 0;
  localparam int MODE_LOCKSTEP = 1;

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_chn_wait_slot.sv
// One output channel: pending counter, DEPTH-entry data FIFO with bypass,
// write-available qualifier and sticky overflow/underflow flags.
module nv_nvdla_sdp_chn_wait_slot
  import nv_nvdla_sdp_cvt_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             biwt,
  input  logic             bdwt,
  input  logic [W-1:0]     din,
  output logic             bawt,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] pend,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_udf_q, err_udf_d;
  logic [W-1:0]     mem_q [DEPTH];

  logic empty, full, push, pop, wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == CNT_FULL);
    bawt  = biwt | ~empty;
    pop   = bdwt & bawt;
    push  = biwt & (~full | pop);
    // An empty FIFO hands din straight through when it is retired the same cycle.
    wr_en = push & ~(empty & pop);
    rd_en = pop & ~empty;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d  = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    err_ovf_d = err_ovf_q | (biwt & full & ~pop);
    err_udf_d = err_udf_q | (bdwt & ~bawt);

    dout    = empty ? din : mem_q[rd_ptr_q];
    pend    = cnt_q;
    err_ovf = err_ovf_q;
    err_udf = err_udf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // NOTE: the storage array is not reset; cnt==0 masks stale entries from dout.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc.sv
// Multi-channel output wait datapath: NCH independent slots plus the
// optional lockstep reduction of the write-enable-complete qualifier.
module nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc
  import nv_nvdla_sdp_cvt_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int W     = 16,
  parameter int MODE  = MODE_INDEP,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic [NCH-1:0]       chn_out_rsci_oswt,
  input  logic [NCH-1:0]       chn_out_rsci_biwt,
  input  logic [NCH-1:0]       chn_out_rsci_bdwt,
  input  logic [NCH*W-1:0]     chn_out_rsci_din,
  output logic [NCH-1:0]       chn_out_rsci_bawt,
  output logic [NCH-1:0]       chn_out_rsci_wen_comp,
  output logic [NCH*W-1:0]     chn_out_rsci_dout,
  output logic [NCH*CNT_W-1:0] chn_out_rsci_pend,
  output logic [NCH-1:0]       chn_out_rsci_err_ovf,
  output logic [NCH-1:0]       chn_out_rsci_err_udf
);

  logic [NCH-1:0] avail;

  for (genvar c = 0; c < NCH; c++) begin : g_slot
    nv_nvdla_sdp_chn_wait_slot #(
      .DEPTH (DEPTH),
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (nvdla_core_clk),
      .rst     (nvdla_core_rst),
      .biwt    (chn_out_rsci_biwt[c]),
      .bdwt    (chn_out_rsci_bdwt[c]),
      .din     (chn_out_rsci_din[c*W +: W]),
      .bawt    (chn_out_rsci_bawt[c]),
      .dout    (chn_out_rsci_dout[c*W +: W]),
      .pend    (chn_out_rsci_pend[c*CNT_W +: CNT_W]),
      .err_ovf (chn_out_rsci_err_ovf[c]),
      .err_udf (chn_out_rsci_err_udf[c])
    );
  end

  // Lockstep: nobody completes unless every requesting channel can.
  always_comb begin
    avail = ~chn_out_rsci_oswt | chn_out_rsci_bawt;
    chn_out_rsci_wen_comp = (MODE == MODE_LOCKSTEP) ? {NCH{&avail}} : avail;
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc.sv
// Directed bench: table of empty-state combinational vectors, then hand-written
// fill/drain, overflow, push+pop, underflow/bypass, lockstep and reset sequences.
module tb_nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc;

  localparam int NCH = 2, DEPTH = 2, W = 16, CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       oswt, biwt, bdwt;
  logic [NCH*W-1:0]     din;

  logic [NCH-1:0]       bawt, wen, ovf, udf;
  logic [NCH*W-1:0]     dout;
  logic [NCH*CNT_W-1:0] pend;

  logic [NCH-1:0]       bawt_l, wen_l, ovf_l, udf_l;
  logic [NCH*W-1:0]     dout_l;
  logic [NCH*CNT_W-1:0] pend_l;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc #(
    .NCH(NCH), .DEPTH(DEPTH), .W(W), .MODE(0)
  ) u_dut_indep (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .chn_out_rsci_oswt     (oswt),
    .chn_out_rsci_biwt     (biwt),
    .chn_out_rsci_bdwt     (bdwt),
    .chn_out_rsci_din      (din),
    .chn_out_rsci_bawt     (bawt),
    .chn_out_rsci_wen_comp (wen),
    .chn_out_rsci_dout     (dout),
    .chn_out_rsci_pend     (pend),
    .chn_out_rsci_err_ovf  (ovf),
    .chn_out_rsci_err_udf  (udf)
  );

  nv_nvdla_sdp_core_y_cvt_chn_out_wait_dp_mc #(
    .NCH(NCH), .DEPTH(DEPTH), .W(W), .MODE(1)
  ) u_dut_lock (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .chn_out_rsci_oswt     (oswt),
    .chn_out_rsci_biwt     (biwt),
    .chn_out_rsci_bdwt     (bdwt),
    .chn_out_rsci_din      (din),
    .chn_out_rsci_bawt     (bawt_l),
    .chn_out_rsci_wen_comp (wen_l),
    .chn_out_rsci_dout     (dout_l),
    .chn_out_rsci_pend     (pend_l),
    .chn_out_rsci_err_ovf  (ovf_l),
    .chn_out_rsci_err_udf  (udf_l)
  );

  typedef struct {
    logic [1:0]  oswt;
    logic [1:0]  biwt;
    logic [31:0] din;
    logic [1:0]  exp_bawt;
    logic [1:0]  exp_wen;
    logic [1:0]  exp_wen_lock;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b11, 2'b11, 32'h2222_1111, 2'b11, 2'b11, 2'b11};
    vecs[1] = '{2'b11, 2'b00, 32'h3333_4444, 2'b00, 2'b00, 2'b00};
    vecs[2] = '{2'b01, 2'b00, 32'h0000_FFFF, 2'b00, 2'b10, 2'b00};
    vecs[3] = '{2'b10, 2'b10, 32'hABCD_0000, 2'b10, 2'b11, 2'b11};
    vecs[4] = '{2'b00, 2'b00, 32'h5A5A_A5A5, 2'b00, 2'b11, 2'b11};
    vecs[5] = '{2'b11, 2'b01, 32'h1234_5678, 2'b01, 2'b01, 2'b00};

    // T1: reset held with both channels requesting and writing
    rst  = 1'b1;
    oswt = 2'b11;
    biwt = 2'b11;
    bdwt = 2'b00;
    din  = 32'h0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      oswt = vecs[i].oswt;
      biwt = vecs[i].biwt;
      din  = vecs[i].din;
      #1;
      check($sformatf("vec%0d_bawt", i), bawt, vecs[i].exp_bawt);
      check($sformatf("vec%0d_wen", i), wen, vecs[i].exp_wen);
      check($sformatf("vec%0d_wen_lock", i), wen_l, vecs[i].exp_wen_lock);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].din);
      tick();
    end

    oswt = 2'b00;
    biwt = 2'b00;
    bdwt = 2'b00;
    rst  = 1'b0;
    tick();
    check("rst_pend", pend, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    check("rst_bawt", bawt, 0);

    // T2: fill ch0 with A1, B2, then drain
    biwt = 2'b01;
    din  = 32'h0000_00A1;
    #1;
    check("t2_bypass_dout", dout[15:0], 16'h00A1);
    tick();
    din = 32'h0000_00B2;
    #1;
    check("t2_pend1", pend[1:0], 1);
    check("t2_fifo_head", dout[15:0], 16'h00A1);
    tick();
    biwt = 2'b00;
    #1;
    check("t2_pend2", pend[1:0], 2);
    check("t2_head_a1", dout[15:0], 16'h00A1);
    check("t2_bawt_pending", bawt, 2'b01);
    bdwt = 2'b01;
    tick();
    check("t2_head_b2", dout[15:0], 16'h00B2);
    check("t2_pend_drain1", pend[1:0], 1);
    tick();
    bdwt = 2'b00;
    #1;
    check("t2_pend_empty", pend[1:0], 0);
    check("t2_no_udf", udf, 0);

    // T3: overflow attempt at full
    biwt = 2'b01;
    din  = 32'h0000_00A1;
    tick();
    din = 32'h0000_00B2;
    tick();
    din = 32'h0000_00C3;
    #1;
    check("t3_pend_full", pend[1:0], 2);
    tick();
    biwt = 2'b00;
    #1;
    check("t3_ovf", ovf, 2'b01);
    check("t3_pend_held", pend[1:0], 2);
    check("t3_head_a1", dout[15:0], 16'h00A1);

    // T4: push and pop together at full
    biwt = 2'b01;
    bdwt = 2'b01;
    din  = 32'h0000_00D4;
    #1;
    check("t4_pop_a1", dout[15:0], 16'h00A1);
    tick();
    biwt = 2'b00;
    #1;
    check("t4_pend_full", pend[1:0], 2);
    check("t4_head_b2", dout[15:0], 16'h00B2);
    tick();
    check("t4_head_d4", dout[15:0], 16'h00D4);
    check("t4_pend1", pend[1:0], 1);
    tick();
    bdwt = 2'b00;
    #1;
    check("t4_pend_empty", pend[1:0], 0);
    check("t4_no_udf", udf, 0);
    check("t4_ovf_sticky", ovf, 2'b01);

    // T5: underflow, then bypass with same-cycle retire
    bdwt = 2'b01;
    #1;
    check("t5_bawt_low", bawt, 2'b00);
    tick();
    bdwt = 2'b00;
    #1;
    check("t5_udf", udf, 2'b01);
    check("t5_pend0", pend[1:0], 0);
    biwt = 2'b01;
    bdwt = 2'b01;
    din  = 32'h0000_0055;
    #1;
    check("t5_bypass_dout", dout[15:0], 16'h0055);
    check("t5_bypass_bawt", bawt, 2'b01);
    tick();
    biwt = 2'b00;
    bdwt = 2'b00;
    #1;
    check("t5_pend_stays0", pend, 0);
    check("t5_udf_only_ch0", udf, 2'b01);
    check("t5_ovf_only_ch0", ovf, 2'b01);

    // T6: lockstep wen_comp reduction
    biwt = 2'b01;
    oswt = 2'b11;
    #1;
    check("t6_lock_blocked", wen_l, 2'b00);
    check("t6_indep", wen, 2'b01);
    oswt = 2'b01;
    #1;
    check("t6_lock_ok", wen_l, 2'b11);
    check("t6_indep_ok", wen, 2'b11);
    biwt = 2'b00;
    oswt = 2'b00;
    tick();

    // Reset mid-operation drops a pending ch1 entry
    biwt = 2'b10;
    din  = 32'h003C_0000;
    tick();
    biwt = 2'b00;
    #1;
    check("mid_pend_ch1", pend[3:2], 1);
    check("mid_head_ch1", dout[31:16], 16'h003C);
    rst = 1'b1;
    din = 32'h0099_0000;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_pend", pend, 0);
    check("mid_rst_pend_lock", pend_l, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_udf", udf, 0);
    check("mid_rst_dout", dout[31:16], 16'h0099);
    check("mid_rst_bawt", bawt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
